fb_pattern_gen: RTL and testbench

- Parametrised framebuffer test-pattern writer that generates one complete frame of pixel writes per start request.
- Drives the framebuffer controller write port (w_addr, color, en_w) and pulses done when the frame is written.
- Generalises the fixed 640x480 bar tester: configurable resolution and colour depth, four selectable patterns, per-frame colour swap, and write backpressure.
- Sits between the frame-ready output of the framebuffer controller and the controller's write port.

---
 rtl/fb_pattern_gen.sv | 136 +++++++++++++
 tb/tb_fb_pattern_gen.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_pattern_gen.sv
// Framebuffer test-pattern writer: one frame of raster-order pixel writes per start; first write 1 cycle after start.
// Backpressure: en_w stays high with w_addr/color held until w_ready accepts; done follows the last accept by 1 cycle.
module fb_pattern_gen #(
  parameter int H_RES    = 640,
  parameter int V_RES    = 480,
  parameter int ADDR_W   = 19,
  parameter int COLOR_W  = 4,
  parameter int BAR_LOG2 = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               swap_en,
  input  logic [COLOR_W-1:0] fg_color,
  input  logic [COLOR_W-1:0] bg_color,
  input  logic               w_ready,
  output logic [ADDR_W-1:0]  w_addr,
  output logic [COLOR_W-1:0] color,
  output logic               en_w,
  output logic               done,
  output logic               busy,
  output logic [15:0]        frame_cnt
);

  // Coordinate counters are widened so the bar-select bit always exists.
  localparam int XC  = $clog2(H_RES);
  localparam int YC  = $clog2(V_RES);
  localparam int X_W = (XC > BAR_LOG2) ? XC : BAR_LOG2 + 1;
  localparam int Y_W = (YC > BAR_LOG2) ? YC : BAR_LOG2 + 1;
  localparam logic [X_W-1:0] X_LAST = X_W'(H_RES - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_RES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [X_W-1:0]     x;
  logic [Y_W-1:0]     y;
  logic [ADDR_W-1:0]  addr;
  logic [1:0]         mode_q;
  logic               swap_q;
  logic [COLOR_W-1:0] fg_q;
  logic [COLOR_W-1:0] bg_q;
  logic               parity;
  logic               accept;
  logic               last_pix;

  assign accept   = (state == RUN) && w_ready;
  assign last_pix = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (accept && last_pix) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      x         <= '0;
      y         <= '0;
      addr      <= '0;
      mode_q    <= '0;
      swap_q    <= 1'b0;
      fg_q      <= '0;
      bg_q      <= '0;
      parity    <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            mode_q <= mode;
            swap_q <= swap_en;
            fg_q   <= fg_color;
            bg_q   <= bg_color;
            x      <= '0;
            y      <= '0;
            addr   <= '0;
          end
        end
        RUN: begin
          if (accept) begin
            // Address tracks y*H_RES+x by plain increment in raster order.
            addr <= addr + ADDR_W'(1);
            if (x == X_LAST) begin
              x <= '0;
              y <= last_pix ? '0 : y + Y_W'(1);
            end else begin
              x <= x + X_W'(1);
            end
          end
        end
        DONE: begin
          frame_cnt <= frame_cnt + 16'd1;
          if (swap_q) parity <= ~parity;
        end
        default: ;
      endcase
    end
  end

  logic [COLOR_W-1:0] col_a, col_b;
  logic               sel_b;

  always_comb begin
    col_a = parity ? bg_q : fg_q;
    col_b = parity ? fg_q : bg_q;
    sel_b = 1'b0;
    case (mode_q)
      2'd0:    sel_b = 1'b0;
      2'd1:    sel_b = x[BAR_LOG2];
      2'd2:    sel_b = y[BAR_LOG2];
      default: sel_b = x[BAR_LOG2] ^ y[BAR_LOG2];
    endcase
    color  = (state == RUN) ? (sel_b ? col_b : col_a) : '0;
    w_addr = (state == RUN) ? addr : '0;
    en_w   = (state == RUN);
    busy   = (state == RUN);
    done   = (state == DONE);
  end

endmodule

// File: tb/tb_fb_pattern_gen.sv
// Scoreboard bench for fb_pattern_gen on an 8x4 frame with 2-pixel bars.
module tb_fb_pattern_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [1:0] mode;
  logic       swap_en;
  logic [3:0] fg_color;
  logic [3:0] bg_color;
  logic       w_ready;
  logic [4:0] w_addr;
  logic [3:0] color;
  logic       en_w;
  logic       done;
  logic       busy;
  logic [15:0] frame_cnt;

  fb_pattern_gen #(
    .H_RES(8), .V_RES(4), .ADDR_W(5), .COLOR_W(4), .BAR_LOG2(1)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .swap_en(swap_en),
    .fg_color(fg_color), .bg_color(bg_color), .w_ready(w_ready),
    .w_addr(w_addr), .color(color), .en_w(en_w), .done(done), .busy(busy),
    .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0] addr;
    logic [3:0] color;
  } pix_t;

  pix_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input int got, input int want);
    n_checks++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, got, want);
  endtask

  // Hand-derived bar masks for 2-pixel bars: x = 0..7 and y = 0..3.
  function automatic logic [3:0] ref_color(input int m, input int a, input int b,
                                           input int px, input int py);
    logic [7:0] xb;
    logic [3:0] yb;
    logic       s;
    xb = 8'b1100_1100;
    yb = 4'b1100;
    case (m)
      0:       s = 1'b0;
      1:       s = xb[px];
      2:       s = yb[py];
      default: s = xb[px] ^ yb[py];
    endcase
    return s ? 4'(b) : 4'(a);
  endfunction

  task automatic push_frame(input int m, input int a, input int b, input int n);
    pix_t p;
    for (int i = 0; i < n; i++) begin
      p.addr  = 5'(i);
      p.color = ref_color(m, a, b, i % 8, i / 8);
      exp_q.push_back(p);
    end
  endtask

  // Monitor: pops the scoreboard on every accepted write.
  int         cyc = 0, acc_cnt = 0, done_cnt = 0, en_cnt = 0;
  int         acc31_cyc = 0, done_cyc = 0, last_en_cyc = 0;
  bit         have_en = 0, prev_en = 0, stall_prev = 0;
  logic [4:0] h_addr;
  logic [3:0] h_col;
  int         gap_q[$];
  pix_t       e;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      acc_cnt = 0; done_cnt = 0; en_cnt = 0;
      have_en = 0; prev_en = 0; stall_prev = 0;
      gap_q.delete();
    end else begin
      if (en_w) begin
        if (!prev_en && have_en) gap_q.push_back(cyc - last_en_cyc - 1);
        last_en_cyc = cyc;
        have_en = 1;
        en_cnt++;
      end
      if (stall_prev && en_w) begin
        check("stall_hold_addr", int'(w_addr), int'(h_addr));
        check("stall_hold_color", int'(color), int'(h_col));
      end
      if (en_w && w_ready) begin
        acc_cnt++;
        if (w_addr == 5'd31) acc31_cyc = cyc;
        if (exp_q.size() == 0) check("unexpected_write", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("pix_addr", int'(w_addr), int'(e.addr));
          check("pix_color", int'(color), int'(e.color));
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      stall_prev = en_w && !w_ready;
      h_addr = w_addr;
      h_col = color;
      prev_en = en_w;
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    w_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Returns in the DONE cycle (1 after the edge); toggle drives w_ready 1,0,0,...
  task automatic wait_done(input int budget, input bit toggle);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget; i++) begin
      if (toggle) w_ready = ((i % 3) == 0);
      @(posedge clk);
      #1;
      if (done) begin
        seen = 1;
        break;
      end
    end
    w_ready = 1'b1;
    check("done_within_budget", int'(seen), 1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; mode = 2'd0; swap_en = 1'b0;
    fg_color = 4'd0; bg_color = 4'd0; w_ready = 1'b1;

    // Reset state
    do_reset();
    check("rst_en_w", int'(en_w), 0);
    check("rst_w_addr", int'(w_addr), 0);
    check("rst_color", int'(color), 0);
    check("rst_done", int'(done), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_frame_cnt", int'(frame_cnt), 0);

    // Mode 0 solid, full-rate sink
    mode = 2'd0; fg_color = 4'd1; bg_color = 4'd2;
    push_frame(0, 1, 2, 32);
    pulse_start();
    check("first_en_w", int'(en_w), 1);
    check("first_busy", int'(busy), 1);
    check("first_w_addr", int'(w_addr), 0);
    wait_done(100, 0);
    @(posedge clk); #1;
    check("m0_en_cycles", en_cnt, 32);
    check("m0_accepts", acc_cnt, 32);
    check("m0_done_count", done_cnt, 1);
    check("m0_done_latency", done_cyc - acc31_cyc, 1);
    check("m0_frame_cnt", int'(frame_cnt), 1);
    check("m0_queue_empty", exp_q.size(), 0);

    // Mode 3 checkerboard
    do_reset();
    mode = 2'd3; fg_color = 4'd4; bg_color = 4'd2;
    push_frame(3, 4, 2, 32);
    pulse_start();
    wait_done(100, 0);
    @(posedge clk); #1;
    check("m3_accepts", acc_cnt, 32);
    check("m3_queue_empty", exp_q.size(), 0);

    // Mode 1 vertical bars with a stalling sink
    do_reset();
    mode = 2'd1; fg_color = 4'd1; bg_color = 4'd2;
    push_frame(1, 1, 2, 32);
    pulse_start();
    wait_done(200, 1);
    @(posedge clk); #1;
    check("m1_accepts", acc_cnt, 32);
    check("m1_done_count", done_cnt, 1);
    check("m1_queue_empty", exp_q.size(), 0);

    // Colour swap across three back-to-back frames
    do_reset();
    mode = 2'd0; fg_color = 4'd1; bg_color = 4'd2; swap_en = 1'b1;
    push_frame(0, 1, 2, 32);
    push_frame(0, 2, 1, 32);
    push_frame(0, 1, 2, 32);
    start = 1'b1;
    begin
      int nd;
      nd = 0;
      for (int i = 0; i < 200; i++) begin
        @(posedge clk); #1;
        if (done) begin
          nd++;
          if (nd == 3) begin
            start = 1'b0;
            break;
          end
        end
      end
      start = 1'b0;
      check("swap_done_seen", nd, 3);
    end
    swap_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("swap_no_fourth", int'(en_w), 0);
    check("swap_frame_cnt", int'(frame_cnt), 3);
    check("swap_gap_count", gap_q.size(), 2);
    while (gap_q.size() > 0) check("swap_gap_len", gap_q.pop_front(), 2);
    check("swap_queue_empty", exp_q.size(), 0);

    // Mid-frame reset in mode 2, then a clean frame
    do_reset();
    mode = 2'd2; fg_color = 4'd1; bg_color = 4'd2;
    push_frame(2, 1, 2, 10);
    pulse_start();
    for (int i = 0; i < 50; i++) begin
      if (acc_cnt >= 10) break;
      @(posedge clk); #1;
    end
    check("rst10_accepts", acc_cnt, 10);
    check("rst10_no_done", done_cnt, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst10_en_w", int'(en_w), 0);
    check("rst10_w_addr", int'(w_addr), 0);
    check("rst10_color", int'(color), 0);
    repeat (5) @(posedge clk);
    #1;
    check("rst10_done_after", done_cnt, 0);
    check("rst10_frame_cnt", int'(frame_cnt), 0);
    check("rst10_queue_empty", exp_q.size(), 0);
    push_frame(2, 1, 2, 32);
    pulse_start();
    wait_done(100, 0);
    @(posedge clk); #1;
    check("m2_accepts", acc_cnt, 32);
    check("m2_frame_cnt", int'(frame_cnt), 1);

    // Start and setting changes during RUN are ignored
    do_reset();
    mode = 2'd0; fg_color = 4'd5; bg_color = 4'd2;
    push_frame(0, 5, 2, 32);
    pulse_start();
    repeat (5) @(posedge clk);
    #1;
    start = 1'b1; mode = 2'd3; fg_color = 4'd7; bg_color = 4'd9;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(100, 0);
    repeat (4) @(posedge clk);
    #1;
    check("ign_en_w", int'(en_w), 0);
    check("ign_accepts", acc_cnt, 32);
    check("ign_done_count", done_cnt, 1);
    check("ign_frame_cnt", int'(frame_cnt), 1);
    check("final_queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
